// File: rtl/contador_pkg.sv
// Shared types and constants for the button conditioner and its downstream up/down counter.
// Holds the channel FSM states, default timing parameters and the counter reset value.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } canal_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 1000;
  localparam int REPEAT_DELAY_DEF    = 50000;
  localparam int REPEAT_PERIOD_DEF   = 10000;

  localparam logic [7:0] CONTADOR_RST = 8'h6A;

  // The single per-channel timer must hold both the delay and the period limits.
  function automatic int timer_width(input int delay_lim, input int period_lim);
    int m;
    m = (delay_lim > period_lim) ? delay_lim : period_lim;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// One button channel: 2-flop synchronizer, debounce, IDLE/DELAY/REPEAT FSM, combinational request.
// Request rises DEBOUNCE_CYCLES+2 edges after the raw press is first sampled; no backpressure.
module debounce_canal
  import contador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic req
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = timer_width(REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [DW-1:0] DEB_MAX     = DW'(DEBOUNCE_CYCLES);
  localparam bit            REPEAT_EN   = (REPEAT_DELAY > 0);
  localparam logic [TW-1:0] DELAY_LAST  = REPEAT_EN ? TW'(REPEAT_DELAY - 1) : '0;
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_SAT   = '1;

  logic          sync_q1;
  logic          sync_q2;
  logic          deb_lvl;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] timer;
  logic          timer_clr;
  logic          delay_hit;
  logic          period_hit;
  canal_state_t  state;
  canal_state_t  state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // Count cycles the synchronized level disagrees with the accepted level; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_q2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_MAX) begin
      deb_lvl <= ~deb_lvl;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + DW'(1);
    end
  end

  // Hits fire on the last count so the registered pulse lands exactly on the limit.
  assign delay_hit  = REPEAT_EN && (timer == DELAY_LAST);
  assign period_hit = (timer == PERIOD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!deb_lvl || timer_clr) begin
      timer <= '0;
    end else if (timer != TIMER_SAT) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!deb_lvl) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = DELAY;
        DELAY:   if (delay_hit) state_nxt = REPEAT;
        REPEAT:  state_nxt = REPEAT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A low debounced level suppresses every request, so release never pulses.
  always_comb begin
    req       = 1'b0;
    timer_clr = 1'b0;
    if (deb_lvl) begin
      case (state)
        IDLE: begin
          req       = 1'b1;
          timer_clr = 1'b1;
        end
        DELAY: begin
          if (delay_hit) begin
            req       = 1'b1;
            timer_clr = 1'b1;
          end
        end
        REPEAT: begin
          if (period_hit) begin
            req       = 1'b1;
            timer_clr = 1'b1;
          end
        end
        default: begin
          req       = 1'b0;
          timer_clr = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Two debounced, auto-repeating button channels feeding registered acrescer/decrecer pulses.
// Pulse appears the cycle after edge DEBOUNCE_CYCLES+3; coincident requests are dropped, no backpressure.
module condicionador_botoes
  import contador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  output logic acrescer,
  output logic decrecer
);

  logic req_up;
  logic req_down;

  debounce_canal #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_canal_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .req   (req_up)
  );

  debounce_canal #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_canal_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .req   (req_down)
  );

  // Dropping both on a tie keeps the counter from seeing a contradictory command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acrescer <= 1'b0;
      decrecer <= 1'b0;
    end else begin
      acrescer <= req_up & ~req_down;
      decrecer <= req_down & ~req_up;
    end
  end

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed scoreboard bench: stimulus queues expected pulse edges, a negedge monitor pops and compares.
module tb_condicionador_botoes;
  import contador_pkg::*;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 5;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic btn_up   = 1'b0;
  logic btn_down = 1'b0;
  logic acrescer;
  logic decrecer;

  always #5 clk = ~clk;

  condicionador_botoes #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .acrescer (acrescer),
    .decrecer (decrecer)
  );

  typedef struct {
    bit up;
    int edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [7:0] cnt;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 8-bit up/down counter used for the integration check.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= CONTADOR_RST;
    else if (acrescer) cnt <= cnt + 8'd1;
    else if (decrecer) cnt <= cnt - 8'd1;
  end

  function automatic void chk(input bit ok, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endfunction

  function automatic void push(input bit up, input int e);
    exp_t x;
    x.up     = up;
    x.edge_n = e;
    exp_q.push_back(x);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk(!acrescer && !decrecer,
          $sformatf("reset_outputs acrescer=%0b decrecer=%0b required 0/0", acrescer, decrecer));
    end else if (acrescer || decrecer) begin
      chk(!(acrescer && decrecer),
          $sformatf("mutual_excl cyc=%0d acrescer=%0b decrecer=%0b required not both", cyc, acrescer, decrecer));
      chk(exp_q.size() != 0,
          $sformatf("unexpected_pulse cyc=%0d acrescer=%0b decrecer=%0b required none", cyc, acrescer, decrecer));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk((e.up == acrescer) && (e.edge_n == cyc),
            $sformatf("pulse_match got %s@%0d required %s@%0d",
                      acrescer ? "acrescer" : "decrecer", cyc,
                      e.up ? "acrescer" : "decrecer", e.edge_n));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clean_press(input bit up, input int hold);
    int e0;
    e0 = cyc + 1;
    push(up, e0 + DEB + 3);
    if (up) btn_up = 1'b1;
    else    btn_down = 1'b1;
    step(hold);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(25);
  endtask

  initial begin
    int e0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // single clean up press, no repeat before release
    clean_press(1'b1, 10);
    step(5);

    // bouncing down button never settles
    for (int i = 0; i < 8; i++) begin
      btn_down = (i % 2 == 0);
      step(1);
    end
    btn_down = 1'b0;
    step(30);

    // long down hold: initial, delay repeat, period repeats, nothing after release
    e0 = cyc + 1;
    push(1'b0, e0 + 7);
    push(1'b0, e0 + 27);
    push(1'b0, e0 + 32);
    push(1'b0, e0 + 37);
    push(1'b0, e0 + 42);
    btn_down = 1'b1;
    step(40);
    btn_down = 1'b0;
    step(30);

    // simultaneous press: coincident requests dropped
    btn_up   = 1'b1;
    btn_down = 1'b1;
    step(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(30);

    // reset mid-hold restarts the press
    e0 = cyc + 1;
    push(1'b1, e0 + 7);
    btn_up = 1'b1;
    step(15);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(1'b1, e0 + DEB + 3);
    step(14);
    btn_up = 1'b0;
    step(30);

    // integration with the downstream counter
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk(cnt == CONTADOR_RST, $sformatf("counter_reset got %0h required %0h", cnt, CONTADOR_RST));
    clean_press(1'b1, 10);
    clean_press(1'b1, 10);
    clean_press(1'b1, 10);
    clean_press(1'b0, 10);
    step(5);
    chk(cnt == 8'h6C, $sformatf("counter_final got %0h required 6c", cnt));

    chk(exp_q.size() == 0, $sformatf("pending_expected got %0d missing pulses required 0", exp_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, required bench completion");
    $fatal(1);
  end

endmodule
